// File: rtl/sort_arb_pkg.sv
// Shared constants, FSM state type and debug view for the sort_arb scheduler.
package sort_arb_pkg;

  localparam int NCH = 8;  // character slots per job
  localparam int CW  = 4;  // character index width
  localparam int WW  = 5;  // weight width

  // Sentinel written into unused slots; all-ones weight sorts them to the end.
  localparam logic [3:0] CHAR_PAD   = 4'hF;
  localparam logic [4:0] WEIGHT_PAD = 5'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Internal state exposed for observation.
  typedef struct packed {
    arb_state_t state;
    logic       ptr;     // last-served requester
    logic       gnt_id;  // owner of the response being presented
  } dbg_t;

endpackage

// File: rtl/sort_arb_rr.sv
// Two-way picker: round-robin on ties, single requester always wins.
// Build option: SORT_ARB_FIXED_PRIO_EN turns it into fixed priority
// (requester 0 wins ties) and removes the pointer register; ptr_o then
// reads constant 1.
module sort_arb_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

`ifdef SORT_ARB_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst_n, accept_i};

  // Requester 0 has absolute priority.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0])      gnt_o = 2'b01;
    else if (req_i[1]) gnt_o = 2'b10;
  end

  assign ptr_o = 1'b1;

`else

  logic ptr_q, ptr_d;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (accept_i) ptr_d = gnt_o[1];
  end

  // Last-served pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b1;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

`endif

endmodule

// File: rtl/sort_arb.sv
// Two-requester scheduler in front of the shared combinational sorter.
// Accepts a job, pads unused slots with sentinels, presents the operands to
// the sorter for one cycle, and returns the sorted characters as a one-cycle
// pulse on resp_valid. Build option: SORT_ARB_FIXED_PRIO_EN (fixed priority
// instead of round-robin in sort_arb_rr).
//
// Handshake: a job on requester i transfers on a rising edge where
// req_valid[i] and req_ready[i] are both high. req_ready is offered only in
// IDLE or RESP, only to the arbitration winner, and never depends on
// resp_valid. Requesters hold valid and data until ready. Responses have no
// backpressure: requester i samples resp_char while resp_valid[i] is high.
module sort_arb
  import sort_arb_pkg::*;
#(
  parameter int NCH = sort_arb_pkg::NCH,
  parameter int CW  = sort_arb_pkg::CW,
  parameter int WW  = sort_arb_pkg::WW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [7:0]            req_len,
  input  logic [2*NCH*CW-1:0]   req_char,
  input  logic [2*NCH*WW-1:0]   req_weight,
  output logic [NCH*CW-1:0]     sort_in_char,
  output logic [NCH*WW-1:0]     sort_in_weight,
  input  logic [NCH*CW-1:0]     sort_out_char,
  output logic [1:0]            resp_valid,
  output logic [NCH*CW-1:0]     resp_char,
  output dbg_t                  dbg_o
);

  localparam int CHW = NCH * CW;
  localparam int WTW = NCH * WW;

  arb_state_t     state_q, state_d;
  logic [1:0]     gnt;
  logic           rr_ptr;
  logic           accept_en;
  logic           accept;
  logic           sel;

  logic [3:0]     len_sel;
  logic [CHW-1:0] char_sel, char_pad;
  logic [WTW-1:0] wt_sel, wt_pad;

  logic [CHW-1:0] op_char_q, op_char_d;
  logic [WTW-1:0] op_wt_q, op_wt_d;
  logic           owner_q, owner_d;
  logic           gnt_id_q, gnt_id_d;
  logic [CHW-1:0] resp_char_q, resp_char_d;

  // Acceptance is possible in IDLE and, overlapping the response, in RESP.
  assign accept_en = (state_q == IDLE) || (state_q == RESP);
  assign req_ready = accept_en ? gnt : 2'b00;
  assign accept    = |req_ready;
  assign sel       = req_ready[1];

  sort_arb_rr u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_valid),
    .accept_i (accept),
    .gnt_o    (gnt),
    .ptr_o    (rr_ptr)
  );

  // Select the winner's operands and overwrite slots at or beyond req_len.
  // Since k < NCH always, k >= len also covers the clamp of len to NCH.
  always_comb begin
    len_sel  = sel ? req_len[7:4] : req_len[3:0];
    char_sel = sel ? req_char[2*CHW-1:CHW]  : req_char[CHW-1:0];
    wt_sel   = sel ? req_weight[2*WTW-1:WTW] : req_weight[WTW-1:0];
    char_pad = char_sel;
    wt_pad   = wt_sel;
    for (int k = 0; k < NCH; k++) begin
      if (k >= int'(len_sel)) begin
        char_pad[(NCH-1-k)*CW +: CW] = CW'(CHAR_PAD);
        wt_pad[(NCH-1-k)*WW +: WW]   = WW'(WEIGHT_PAD);
      end
    end
  end

  // Next state and response outputs.
  always_comb begin
    state_d    = state_q;
    resp_valid = 2'b00;
    case (state_q)
      IDLE: if (accept) state_d = SORT;
      SORT: state_d = RESP;
      RESP: begin
        resp_valid = gnt_id_q ? 2'b10 : 2'b01;
        state_d    = accept ? SORT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operands load on accept, result loads in SORT.
  always_comb begin
    op_char_d   = op_char_q;
    op_wt_d     = op_wt_q;
    owner_d     = owner_q;
    gnt_id_d    = gnt_id_q;
    resp_char_d = resp_char_q;
    if (accept) begin
      op_char_d = char_pad;
      op_wt_d   = wt_pad;
      owner_d   = sel;
    end
    if (state_q == SORT) begin
      resp_char_d = sort_out_char;
      gnt_id_d    = owner_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand, owner and result registers; an async reset drops any job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_char_q   <= '0;
      op_wt_q     <= '0;
      owner_q     <= 1'b0;
      gnt_id_q    <= 1'b0;
      resp_char_q <= '0;
    end else begin
      op_char_q   <= op_char_d;
      op_wt_q     <= op_wt_d;
      owner_q     <= owner_d;
      gnt_id_q    <= gnt_id_d;
      resp_char_q <= resp_char_d;
    end
  end

  assign sort_in_char   = op_char_q;
  assign sort_in_weight = op_wt_q;
  assign resp_char      = resp_char_q;
  assign dbg_o          = '{state: state_q, ptr: rr_ptr, gnt_id: gnt_id_q};

endmodule
